// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: FSM state encoding and default RAM window bounds shared by the
// data-memory arbiter and its testbench.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  localparam logic [7:0] DEF_ADDR_LO = 8'h80;
  localparam logic [7:0] DEF_ADDR_HI = 8'hDF;

endpackage

// File: rtl/dmem_arb_grant.sv
// dmem_arb_grant: two-way request picker producing a one-hot grant.
// Default build gives fixed priority to requester 0. Defining DMEM_ARB_RR_EN
// switches contention handling to round-robin, where the requester that did
// not win last time (last_grant: 0 = requester 0, 1 = requester 1) wins.
module dmem_arb_grant (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef DMEM_ARB_RR_EN
  // Round-robin: on contention the requester other than last_grant wins
  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
  end
`else
  // last_grant only matters for round-robin builds
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Fixed priority: requester 0 always beats requester 1
  always_comb begin
    grant    = 2'b00;
    grant[0] = valid[0];
    grant[1] = valid[1] & ~valid[0];
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM (window ADDR_LO..ADDR_HI)
// between the CPU load/store unit (requester 0) and the DMA/IO engine
// (requester 1). One transaction in flight: IDLE accepts, ACCESS lets the RAM
// sample address/write-enable, RESP returns data/error to the owner.
// Optional round-robin arbitration is enabled with `define DMEM_ARB_RR_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int                ADDR_W  = 8,
  parameter int                DATA_W  = 8,
  parameter logic [ADDR_W-1:0] ADDR_LO = ADDR_W'(DEF_ADDR_LO),
  parameter logic [ADDR_W-1:0] ADDR_HI = ADDR_W'(DEF_ADDR_HI)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req0_we,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req1_we,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state;
  arb_state_t        state_next;
  logic [1:0]        grant;
  logic              last_grant;
  logic              owner;
  logic              err;
  logic              is_write;
  logic              sel;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic              in_range;
  logic              accept;

  dmem_arb_grant u_grant (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Request fields of whichever requester currently holds the grant
  assign sel       = grant[1];
  assign sel_addr  = sel ? req1_addr  : req0_addr;
  assign sel_wdata = sel ? req1_wdata : req0_wdata;
  assign sel_we    = sel ? req1_we    : req0_we;
  assign in_range  = (sel_addr >= ADDR_LO) && (sel_addr <= ADDR_HI);
  assign accept    = (state == ST_IDLE) && (grant != 2'b00);

  // State register; reset abandons any in-flight transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Latch the accepted request and drive the RAM; write enable lives for exactly the ACCESS cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      owner      <= 1'b0;
      err        <= 1'b0;
      is_write   <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      mem_addr   <= sel_addr;
      mem_wdata  <= sel_wdata;
      mem_we     <= sel_we & in_range;
      owner      <= sel;
      err        <= ~in_range;
      is_write   <= sel_we;
      last_grant <= sel;
    end else if (state == ST_ACCESS) begin
      mem_we     <= 1'b0;
    end
  end

  // Next state, request handshakes and the response routed to the owner only
  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp_rdata  = '0;
    rsp_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        req0_ready = grant[0];
        req1_ready = grant[1];
        if (grant != 2'b00) begin
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp0_valid = ~owner;
        rsp1_valid = owner;
        rsp_err    = err;
        rsp_rdata  = (is_write || err) ? '0 : mem_rdata;
        if (owner ? rsp1_ready : rsp0_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a
// transaction-level reference model (phase of the single outstanding request,
// shadow RAM contents, arbitration rule). Honors DMEM_ARB_RR_EN when defined.
module tb_dmem_arbiter;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       we;
    int         hold;
  } req_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_addr = '0, req1_addr = '0;
  logic [7:0] req0_wdata = '0, req1_wdata = '0;
  logic       req0_we = 1'b0, req1_we = 1'b0;
  logic       rsp0_valid, rsp1_valid;
  logic       rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;

  logic       preload_en = 1'b0;
  logic [7:0] preload_addr = '0, preload_data = '0;
  logic [7:0] ram [256];
  logic [7:0] ref_mem [256];

  int   vectors = 0;
  int   miscompares = 0;
  int   we_cycles = 0;
  int   m_writes = 0;
  int   m_phase = 0;
  int   m_owner = 0;
  bit   m_last = 1'b1;
  logic [7:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  bit   m_we = 1'b0, m_err = 1'b0;
  int   m_hold = 0;
  bit   pres0 = 1'b0, pres1 = 1'b0;
  req_t q0[$];
  req_t q1[$];
  int   obs_grants[$];

  dmem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_we    (req0_we),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_we    (req1_we),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous read-first RAM seen by the arbiter, with a preload port for setup
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we === 1'b1) ram[mem_addr] = mem_wdata;
    else if (preload_en) ram[preload_addr] = preload_data;
  end

  // Count cycles with the RAM write enable high
  always @(negedge clk) begin
    if (rst_n && mem_we === 1'b1) we_cycles++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input bit v0, input bit v1);
    int w;
    w = -1;
    if (v0 && v1) begin
`ifdef DMEM_ARB_RR_EN
      w = m_last ? 0 : 1;
`else
      w = 0;
`endif
    end else if (v0) begin
      w = 0;
    end else if (v1) begin
      w = 1;
    end
    return w;
  endfunction

  // One clock of stimulus, output checks and reference-model advance
  task automatic applyStimulus(input bit eager);
    int   g;
    req_t it;
    bit   inr;
    @(negedge clk);
    if (!pres0 && q0.size() > 0 && (eager || $urandom_range(0, 2) == 0)) pres0 = 1'b1;
    if (!pres1 && q1.size() > 0 && (eager || $urandom_range(0, 2) == 0)) pres1 = 1'b1;
    req0_valid = pres0;
    req1_valid = pres1;
    if (pres0) begin
      req0_addr = q0[0].addr; req0_wdata = q0[0].wdata; req0_we = q0[0].we;
    end else begin
      req0_addr = 8'($urandom); req0_wdata = 8'($urandom); req0_we = 1'($urandom);
    end
    if (pres1) begin
      req1_addr = q1[0].addr; req1_wdata = q1[0].wdata; req1_we = q1[0].we;
    end else begin
      req1_addr = 8'($urandom); req1_wdata = 8'($urandom); req1_we = 1'($urandom);
    end
    rsp0_ready = (m_phase == 2 && m_owner == 0) ? (m_hold == 0) : 1'($urandom);
    rsp1_ready = (m_phase == 2 && m_owner == 1) ? (m_hold == 0) : 1'($urandom);
    #1;
    g = (m_phase == 0) ? pick(pres0, pres1) : -1;
    checkOutput("req0_ready", req0_ready, g == 0);
    checkOutput("req1_ready", req1_ready, g == 1);
    checkOutput("rsp0_valid", rsp0_valid, m_phase == 2 && m_owner == 0);
    checkOutput("rsp1_valid", rsp1_valid, m_phase == 2 && m_owner == 1);
    checkOutput("rsp_rdata", rsp_rdata, (m_phase == 2) ? m_rdata : 8'h00);
    checkOutput("rsp_err", rsp_err, (m_phase == 2) ? m_err : 1'b0);
    checkOutput("mem_we", mem_we, (m_phase == 1) ? m_we : 1'b0);
    checkOutput("mem_addr", mem_addr, m_addr);
    checkOutput("mem_wdata", mem_wdata, m_wdata);
    if (req0_ready === 1'b1 || req1_ready === 1'b1) obs_grants.push_back((req1_ready === 1'b1) ? 1 : 0);
    case (m_phase)
      0: begin
        if (g >= 0) begin
          if (g == 0) begin it = q0.pop_front(); pres0 = 1'b0; end
          else begin it = q1.pop_front(); pres1 = 1'b0; end
          inr     = (it.addr >= 8'h80) && (it.addr <= 8'hDF);
          m_owner = g;
          m_last  = (g == 1);
          m_addr  = it.addr;
          m_wdata = it.wdata;
          m_err   = !inr;
          m_we    = it.we && inr;
          m_rdata = (it.we || !inr) ? 8'h00 : ref_mem[it.addr];
          if (it.we && inr) begin
            ref_mem[it.addr] = it.wdata;
            m_writes++;
          end
          m_hold  = it.hold;
          m_phase = 1;
        end
      end
      1: m_phase = 2;
      default: begin
        if (m_hold == 0) m_phase = 0;
        else m_hold--;
      end
    endcase
  endtask

  task automatic drain(input bit eager, input int max_cycles);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_phase != 0) && n < max_cycles) begin
      applyStimulus(eager);
      n++;
    end
    checkOutput("drain_bound", n < max_cycles, 1'b1);
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    pres0 = 1'b0; pres1 = 1'b0;
    m_phase = 0; m_last = 1'b1; m_addr = '0; m_wdata = '0; m_hold = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic req_t mk(input logic [7:0] a, input logic [7:0] d, input logic w, input int h);
    req_t r;
    r.addr = a; r.wdata = d; r.we = w; r.hold = h;
    return r;
  endfunction

  initial begin
    int guard;
    int exp_g;
    int obs_g;
    logic [7:0] v;
    logic [7:0] a;

    // Reset state, asserted before any clock edge
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_mem_we", mem_we, 1'b0);
    checkOutput("rst_mem_addr", mem_addr, 8'h00);
    checkOutput("rst_mem_wdata", mem_wdata, 8'h00);
    checkOutput("rst_req0_ready", req0_ready, 1'b0);
    checkOutput("rst_req1_ready", req1_ready, 1'b0);
    checkOutput("rst_rsp0_valid", rsp0_valid, 1'b0);
    checkOutput("rst_rsp1_valid", rsp1_valid, 1'b0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 8'h00);
    checkOutput("rst_rsp_err", rsp_err, 1'b0);

    // Preload the RAM window with random bytes while reset is held
    for (int i = 8'h80; i <= 8'hDF; i++) begin
      @(negedge clk);
      v = 8'($urandom);
      preload_en = 1'b1; preload_addr = 8'(i); preload_data = v;
      ref_mem[i] = v;
    end
    @(negedge clk);
    preload_en = 1'b0;
    applyReset();

    $display("[TB] step 1: requester 0 write then read back 0x90");
    q0.push_back(mk(8'h90, 8'hA5, 1'b1, 0));
    q0.push_back(mk(8'h90, 8'h00, 1'b0, 0));
    drain(1'b1, 50);

    $display("[TB] step 2: requester 1 out-of-range writes and window-edge reads");
    q1.push_back(mk(8'h7F, 8'h3C, 1'b1, 0));
    q1.push_back(mk(8'hE0, 8'hC3, 1'b1, 0));
    q1.push_back(mk(8'h80, 8'h00, 1'b0, 0));
    q1.push_back(mk(8'hDF, 8'h00, 1'b0, 0));
    drain(1'b1, 50);

    $display("[TB] step 3: response held for 5 cycles while requester 1 waits");
    q0.push_back(mk(8'h90, 8'h00, 1'b0, 5));
    q1.push_back(mk(8'h81, 8'h00, 1'b0, 0));
    drain(1'b1, 60);

    $display("[TB] step 4: requester 0 read while requester 1 write is pending");
    q1.push_back(mk(8'hB0, 8'h5A, 1'b1, 0));
    q0.push_back(mk(8'hB0, 8'h00, 1'b0, 1));
    q0.push_back(mk(8'hB0, 8'h00, 1'b0, 0));
    drain(1'b1, 60);

    $display("[TB] step 5: reset during the ACCESS cycle of a write");
    q0.push_back(mk(8'hA0, 8'h11, 1'b1, 0));
    drain(1'b1, 50);
    q0.push_back(mk(8'hA0, 8'h22, 1'b1, 0));
    guard = 0;
    while (m_phase != 1 && guard < 20) begin
      applyStimulus(1'b1);
      guard++;
    end
    checkOutput("rst_accept_bound", guard < 20, 1'b1);
    @(posedge clk);
    #2;
    checkOutput("abort_we_before", mem_we, 1'b1);
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_we_drop", mem_we, 1'b0);
    checkOutput("abort_addr", mem_addr, 8'h00);
    checkOutput("abort_rsp0", rsp0_valid, 1'b0);
    ref_mem[8'hA0] = 8'h11;
    m_writes--;
    applyReset();
    repeat (4) applyStimulus(1'b1);
    q0.push_back(mk(8'hA0, 8'h00, 1'b0, 0));
    drain(1'b1, 50);

    $display("[TB] step 6: both requesters valid every cycle after reset");
    applyReset();
    obs_grants.delete();
    for (int i = 0; i < 12; i++) begin
      q0.push_back(mk(8'(8'h84 + i), 8'($urandom), 1'($urandom), 0));
      q1.push_back(mk(8'(8'hC0 + i), 8'($urandom), 1'($urandom), 0));
    end
    drain(1'b1, 200);
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp_g = i % 2;
`else
      exp_g = 0;
`endif
      obs_g = (i < obs_grants.size()) ? obs_grants[i] : -1;
      checkOutput("contend_grant_order", obs_g, exp_g);
    end

    $display("[TB] step 7: randomized traffic from both requesters");
    for (int i = 0; i < 50; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(128, 223));
      q0.push_back(mk(a, 8'($urandom), 1'($urandom), int'($urandom_range(0, 3))));
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(128, 223));
      q1.push_back(mk(a, 8'($urandom), 1'($urandom), int'($urandom_range(0, 3))));
    end
    drain(1'b0, 3000);

    repeat (2) applyStimulus(1'b0);
    checkOutput("we_pulse_total", we_cycles, m_writes);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
